transmissor_paridade: RTL and testbench
=======================================

// Module: transmissor_paridade
// PURPOSE
//  Transmit side of the 5-bit + parity link. Accepts a 5-bit word (b1..b5) over a valid/ready handshake.
//  Computes the parity bit bp and shifts a framed serial stream onto the line.
//  The far end deserialises the frame and feeds b1..b5,bp to verificador_paridade.
//  Also presents bp in parallel for direct hookup to the combinational verifier.
// PARAMETERS
//  CLKS_PER_BIT  4  clock cycles per serial bit (>=1)
//  PARITY_ODD    0  0: even parity, bp = b1^b2^b3^b4^b5; 1: odd parity, bp = ~(b1^..^b5)
// PORTS
//  clk           in   1  single clock, rising edge
//  rst_n         in   1  reset; one clock; reset is asynchronous and active-low
//  dado          in   5  word to send: dado[4]=b1 ... dado[0]=b5
//  valid_in      in   1  dado is valid
//  ready_out     out  1  transmitter can accept a word (high only in IDLE)
//  tx_serial     out  1  serial line, idles high
//  tx_ativo      out  1  high while a frame is on the line (START..STOP)
//  quadro_fim    out  1  one-cycle pulse in the last cycle of STOP
//  paridade_out  out  1  bp of the most recently accepted word (registered)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; tx_serial=1; tx_ativo=0; quadro_fim=0; paridade_out=0.
//  - Reset clears counters and the shift register. ready_out=1 as soon as the state is IDLE.
//  - Frame, 8 bits, each held exactly CLKS_PER_BIT cycles: start(0), b1, b2, b3, b4, b5, bp, stop(1).
//  - Total frame = 8*CLKS_PER_BIT cycles.
//  - Handshake: word accepted on the rising edge where valid_in&&ready_out.
//  - On accept: dado and bp are latched and paridade_out updates. State moves to START.
//  - tx_serial=0 from the very next cycle (latency 1). dado may change after acceptance.
//  - ready_out = (state==IDLE), combinational from the state register, so it falls in the cycle after accept.
//  - States and transitions:
//      IDLE     -> START    on accept
//      START    -> DADOS    after CLKS_PER_BIT cycles
//      DADOS    -> PARIDADE after 5 bits (bit index 0..4, MSB first)
//      PARIDADE -> STOP     after CLKS_PER_BIT cycles
//      STOP     -> IDLE     after CLKS_PER_BIT cycles
//  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps; it reloads to 0 on every state change.
//  - Bit index is 3 bits wide.
//  - quadro_fim is asserted when state==STOP and baud count == CLKS_PER_BIT-1.
//  - Back-to-back words: IDLE lasts >=1 cycle between frames.
//  - A word with valid_in held high is accepted in that IDLE cycle. The line stays 1 in IDLE, so the effective stop is CLKS_PER_BIT+1 cycles.
//  - valid_in outside IDLE is ignored; no word is lost or duplicated because ready_out=0 there.
//  - Reset mid-frame: line returns to 1 immediately and the frame is abandoned. The partial frame must not be retransmitted.
//  - tx_serial, tx_ativo and quadro_fim are registered outputs (glitch-free line).
// STRUCTURE
//  - Package pkg_paridade holds:
//      state enum: IDLE, START, DADOS, PARIDADE, STOP
//      localparam FRAME_BITS=8 and DATA_BITS=5
//      function calc_paridade(dado, odd), shared with the receiver and the verifier bench
//  - One sub-module: contador_baud (counter with clear, terminal-count output tc).
//  - The FSM, shift register and parity logic stay in this module.
// TESTING
//  1. Reset: rst_n=0 for 3 cycles mid-frame -> tx_serial=1, ready_out=1 and tx_ativo=0 immediately.
//     After release the line stays 1 and no partial bits are emitted.
//  2. CLKS_PER_BIT=4, dado=5'b00000, single valid pulse:
//     -> line 0,0,0,0,0,0,0,1 (4 cycles each); paridade_out=0; quadro_fim pulses at cycle 32 after accept.
//  3. dado=5'b10110 (b1=1, b2=0, b3=1, b4=1, b5=0):
//     -> line 0,1,0,1,1,0,1,1; paridade_out=1. With PARITY_ODD=1 the parity bit is 0.
//  4. valid_in held high with words 5'b11111 then 5'b00001:
//     -> both frames sent, bp=1 then 1, exactly one IDLE cycle between them.
//     -> ready_out low for the full 32 cycles of each frame.
//  5. Loopback of all 32 words: bench deserialiser -> verificador_paridade -> S=0 for every word.
//     Flipping any single serial bit in the model -> S=1.
//  6. CLKS_PER_BIT=1: frame lasts 8 cycles and back-to-back throughput is one word per 9 cycles.

Source files
------------

// File: rtl/transmissor_paridade_pkg.sv
// Shared definitions for the 5-bit + parity link: FSM states, frame sizes and the parity function.
// Rev 1.0
`default_nettype none

package pkg_paridade;

   localparam int FRAME_BITS = 8;
   localparam int DATA_BITS  = 5;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      DADOS    = 3'd2,
      PARIDADE = 3'd3,
      STOP     = 3'd4
   } estado_t;

   function automatic logic calc_paridade(input logic [DATA_BITS-1:0] dado, input logic odd);
      return (^dado) ^ odd;
   endfunction

endpackage

`default_nettype wire

// File: rtl/transmissor_paridade_contador_baud.sv
// contador_baud: baud-period counter 0..CLKS_PER_BIT-1 with clear and terminal-count flags.
// Rev 1.0
`default_nettype none

module contador_baud #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc,
   output logic o_tc_next
);

   localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0] C_LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] r_count;
   logic [W-1:0] w_count_next;

   always_comb begin
      w_count_next = r_count;
      if (i_clr) begin
         w_count_next = '0;
      end else if (i_en) begin
         if (r_count == C_LAST) begin
            w_count_next = '0;
         end else begin
            w_count_next = r_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_next;
      end
   end

   assign o_tc      = (r_count == C_LAST);
   // Lets the parent register a "last cycle of the bit" flag without a cycle of lag.
   assign o_tc_next = (w_count_next == C_LAST);

endmodule

`default_nettype wire

// File: rtl/transmissor_paridade.sv
// transmissor_paridade: accepts a 5-bit word, appends parity and serialises start,b1..b5,bp,stop.
// Rev 1.0
`default_nettype none

module transmissor_paridade
   import pkg_paridade::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] dado,
   input  logic                 valid_in,
   output logic                 ready_out,
   output logic                 tx_serial,
   output logic                 tx_ativo,
   output logic                 quadro_fim,
   output logic                 paridade_out
);

   localparam logic [2:0] C_LAST_IDX = 3'(DATA_BITS - 1);

   estado_t              r_state;
   estado_t              w_next;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_next;
   logic [2:0]           r_idx;
   logic [2:0]           w_idx_next;
   logic                 r_bp;
   logic                 w_bp_next;
   logic                 w_tc;
   logic                 w_tc_next;
   logic                 w_tx_next;
   logic                 r_tx;
   logic                 r_ativo;
   logic                 r_fim;

   contador_baud #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_contador_baud (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     ((r_state == IDLE) || (w_next != r_state)),
      .i_en      (1'b1),
      .o_tc      (w_tc),
      .o_tc_next (w_tc_next)
   );

   always_comb begin
      w_next       = r_state;
      w_shift_next = r_shift;
      w_idx_next   = r_idx;
      w_bp_next    = r_bp;
      case (r_state)
         IDLE: begin
            if (valid_in) begin
               w_next       = START;
               w_shift_next = dado;
               w_bp_next    = calc_paridade(dado, PARITY_ODD);
               w_idx_next   = 3'd0;
            end
         end
         START: begin
            if (w_tc) w_next = DADOS;
         end
         DADOS: begin
            if (w_tc) begin
               if (r_idx == C_LAST_IDX) begin
                  w_next = PARIDADE;
               end else begin
                  w_idx_next   = r_idx + 3'd1;
                  w_shift_next = {r_shift[DATA_BITS-2:0], 1'b0};
               end
            end
         end
         PARIDADE: begin
            if (w_tc) w_next = STOP;
         end
         STOP: begin
            if (w_tc) begin
               w_next     = IDLE;
               w_idx_next = 3'd0;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Line value is decided from the next state so the registered output lines up with it.
   always_comb begin
      w_tx_next = 1'b1;
      case (w_next)
         START:    w_tx_next = 1'b0;
         DADOS:    w_tx_next = w_shift_next[DATA_BITS-1];
         PARIDADE: w_tx_next = w_bp_next;
         default:  w_tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_idx   <= 3'd0;
         r_bp    <= 1'b0;
         r_tx    <= 1'b1;
         r_ativo <= 1'b0;
         r_fim   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_shift <= w_shift_next;
         r_idx   <= w_idx_next;
         r_bp    <= w_bp_next;
         r_tx    <= w_tx_next;
         r_ativo <= (w_next != IDLE);
         r_fim   <= (w_next == STOP) && w_tc_next;
      end
   end

   assign ready_out    = (r_state == IDLE);
   assign tx_serial    = r_tx;
   assign tx_ativo     = r_ativo;
   assign quadro_fim   = r_fim;
   assign paridade_out = r_bp;

endmodule

`default_nettype wire

// File: tb/tb_transmissor_paridade.sv
// tb_transmissor_paridade: directed checks of framing, parity, handshake and reset for the transmitter.
// Rev 1.0
`default_nettype none

module tb_transmissor_paridade;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] dado  = 5'b0;
   logic [2:0] valid = 3'b0;

   wire [2:0] w_rdy;
   wire [2:0] w_tx;
   wire [2:0] w_act;
   wire [2:0] w_fim;
   wire [2:0] w_par;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   transmissor_paridade #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut_even (
      .clk(clk), .rst_n(rst_n), .dado(dado), .valid_in(valid[0]),
      .ready_out(w_rdy[0]), .tx_serial(w_tx[0]), .tx_ativo(w_act[0]),
      .quadro_fim(w_fim[0]), .paridade_out(w_par[0]));

   transmissor_paridade #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut_odd (
      .clk(clk), .rst_n(rst_n), .dado(dado), .valid_in(valid[1]),
      .ready_out(w_rdy[1]), .tx_serial(w_tx[1]), .tx_ativo(w_act[1]),
      .quadro_fim(w_fim[1]), .paridade_out(w_par[1]));

   transmissor_paridade #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut_fast (
      .clk(clk), .rst_n(rst_n), .dado(dado), .valid_in(valid[2]),
      .ready_out(w_rdy[2]), .tx_serial(w_tx[2]), .tx_ativo(w_act[2]),
      .quadro_fim(w_fim[2]), .paridade_out(w_par[2]));

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Presents one word for a single cycle; returns at the negedge of the first frame cycle.
   task automatic send(input int sel, input logic [4:0] word, input string name);
      dado       = word;
      valid[sel] = 1'b1;
      checks++;
      if (w_rdy[sel] !== 1'b1) begin
         failures++;
         $display("FAIL %s ready_before_accept: got=%b exp=1", name, w_rdy[sel]);
      end
      @(negedge clk);
      valid[sel] = 1'b0;
      dado       = ~word;
   endtask

   // Samples a whole frame starting in its first cycle; ends in the cycle after STOP.
   task automatic capture(input int sel, input logic [7:0] exp_frame, input logic exp_par,
                          input string name, output logic [7:0] got);
      int cpb;
      int n;
      int bad_line;
      int bad_act;
      int bad_rdy;
      int bad_fim;
      int fim_at;
      cpb      = (sel == 2) ? 1 : 4;
      n        = 8 * cpb;
      bad_line = 0;
      bad_act  = 0;
      bad_rdy  = 0;
      bad_fim  = 0;
      fim_at   = -1;
      got      = 8'hFF;
      for (int c = 0; c < n; c++) begin
         if (w_tx[sel] !== exp_frame[7 - c / cpb]) bad_line++;
         if ((c % cpb) == (cpb / 2)) got[7 - c / cpb] = w_tx[sel];
         if (w_act[sel] !== 1'b1) bad_act++;
         if (w_rdy[sel] !== 1'b0) bad_rdy++;
         if (w_fim[sel] === 1'b1) begin
            if (fim_at < 0) fim_at = c + 1;
            if (c != n - 1) bad_fim++;
         end else if (c == n - 1) begin
            bad_fim++;
         end
         @(negedge clk);
      end
      checks++;
      if (bad_line != 0) begin
         failures++;
         $display("FAIL %s line: got=%b exp=%b (%0d bad cycles)", name, got, exp_frame, bad_line);
      end
      checks++;
      if (bad_act != 0 || bad_rdy != 0) begin
         failures++;
         $display("FAIL %s ativo/ready during frame: bad_ativo=%0d bad_ready=%0d exp 0/0", name, bad_act, bad_rdy);
      end
      checks++;
      if (bad_fim != 0) begin
         failures++;
         $display("FAIL %s quadro_fim: first pulse at cycle %0d exp %0d", name, fim_at, n);
      end
      checks++;
      if (w_par[sel] !== exp_par) begin
         failures++;
         $display("FAIL %s paridade_out: got=%b exp=%b", name, w_par[sel], exp_par);
      end
      checks++;
      if (w_rdy[sel] !== 1'b1 || w_tx[sel] !== 1'b1 || w_act[sel] !== 1'b0 || w_fim[sel] !== 1'b0) begin
         failures++;
         $display("FAIL %s idle after frame: rdy/tx/ativo/fim got=%b%b%b%b exp=1110", name,
                  w_rdy[sel], w_tx[sel], w_act[sel], w_fim[sel]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (w_tx !== 3'b111 || w_rdy !== 3'b111 || w_act !== 3'b000 || w_fim !== 3'b000 || w_par !== 3'b000) begin
         failures++;
         $display("FAIL reset_state: tx=%b rdy=%b act=%b fim=%b par=%b exp 111/111/000/000/000",
                  w_tx, w_rdy, w_act, w_fim, w_par);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_zero();
      logic [7:0] got;
      send(0, 5'b00000, "zero");
      capture(0, 8'b00000001, 1'b0, "zero", got);
   endtask

   task automatic test_pattern();
      logic [7:0] got;
      send(0, 5'b10110, "even_10110");
      capture(0, 8'b01011011, 1'b1, "even_10110", got);
      send(1, 5'b10110, "odd_10110");
      capture(1, 8'b01011001, 1'b0, "odd_10110", got);
   endtask

   task automatic test_back_to_back();
      logic [7:0] got;
      dado     = 5'b11111;
      valid[0] = 1'b1;
      @(negedge clk);
      dado = 5'b00001;
      capture(0, 8'b01111111, 1'b1, "b2b_first", got);
      @(negedge clk);
      valid[0] = 1'b0;
      capture(0, 8'b00000111, 1'b1, "b2b_second", got);
   endtask

   task automatic test_loopback();
      logic [7:0] got;
      logic [7:0] flipped;
      logic [4:0] w;
      logic       bp;
      int         bad_flip;
      for (int i = 0; i < 32; i++) begin
         w  = 5'(i);
         bp = w[4] ^ w[3] ^ w[2] ^ w[1] ^ w[0];
         send(0, w, "loopback");
         capture(0, {1'b0, w, bp, 1'b1}, bp, "loopback", got);
         checks++;
         if ((^got[6:1]) !== 1'b0 || got[6:2] !== w) begin
            failures++;
            $display("FAIL loopback word=%b: rx_data=%b S=%b exp data=%b S=0", w, got[6:2], ^got[6:1], w);
         end
         bad_flip = 0;
         for (int j = 1; j <= 6; j++) begin
            flipped    = got;
            flipped[j] = ~flipped[j];
            if ((^flipped[6:1]) !== 1'b1) bad_flip++;
         end
         checks++;
         if (bad_flip != 0) begin
            failures++;
            $display("FAIL loopback_flip word=%b: %0d flips gave S=0 exp S=1", w, bad_flip);
         end
      end
   endtask

   task automatic test_fast();
      logic [7:0] got;
      int         rises[$];
      logic       prev;
      send(2, 5'b10110, "fast");
      capture(2, 8'b01011011, 1'b1, "fast", got);
      dado     = 5'b01010;
      valid[2] = 1'b1;
      prev     = w_act[2];
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (w_act[2] === 1'b1 && prev !== 1'b1) rises.push_back(c);
         prev = w_act[2];
      end
      valid[2] = 1'b0;
      checks++;
      if (rises.size() < 3) begin
         failures++;
         $display("FAIL fast_throughput: frame starts=%0d exp>=3", rises.size());
      end else if ((rises[1] - rises[0]) != 9 || (rises[2] - rises[1]) != 9) begin
         failures++;
         $display("FAIL fast_throughput: spacing %0d,%0d exp 9,9", rises[1] - rises[0], rises[2] - rises[1]);
      end
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      send(0, 5'b10101, "mid_reset");
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (w_tx[0] !== 1'b1 || w_rdy[0] !== 1'b1 || w_act[0] !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_immediate: tx/rdy/ativo got=%b%b%b exp=110", w_tx[0], w_rdy[0], w_act[0]);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (w_par[0] !== 1'b0 || w_fim[0] !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_par: par/fim got=%b%b exp=00", w_par[0], w_fim[0]);
      end
      rst_n = 1'b1;
      bad   = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (w_tx[0] !== 1'b1 || w_act[0] !== 1'b0 || w_rdy[0] !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL mid_reset_no_retransmit: %0d cycles off idle exp 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_pattern();
      test_back_to_back();
      test_loopback();
      test_fast();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
